// File: rtl/snake_head_mover.sv
// ============================================================================
// snake_head_mover
// ----------------------------------------------------------------------------
// Owns the snake head position on an 8x8 grid and the current travel
// direction. Button presses become a direction request that cannot reverse
// the snake onto itself. The head steps once per move tick. The game ends
// when the wall checker reports a collision, or when the step would leave
// the grid.
//
// Head encoding : head[5:3] = row, head[2:0] = col
// Direction     : RIGHT=00, LEFT=01, DOWN=10, UP=11
// State         : IDLE=00, RUN=01, DEAD=10
//
// Parameters
//   TICK_CYCLES  clock cycles per move tick (>= 2)
//   START_HEAD   head position after reset / re-init
//   START_DIR    direction after reset / re-init
//
// Ports
//   clock      in   system clock, all state on the rising edge
//   reset      in   synchronous active-high reset, overrides everything
//   start      in   one-cycle pulse: IDLE->RUN, DEAD->IDLE
//   btn_up     in   level, request UP
//   btn_down   in   level, request DOWN
//   btn_left   in   level, request LEFT
//   btn_right  in   level, request RIGHT
//   colide     in   wall checker flag for the current head/direction
//   head       out  registered head position {row,col}
//   direction  out  registered direction the next move will use
//   moved      out  one-cycle pulse in the cycle the new head is visible
//   game_over  out  high while in DEAD
//   state      out  current controller state
// ============================================================================
module snake_head_mover #(
   parameter int unsigned TICK_CYCLES = 5_000_000,
   parameter logic [5:0]  START_HEAD  = 6'b011011,
   parameter logic [1:0]  START_DIR   = 2'b00
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       colide,
   output logic [5:0] head,
   output logic [1:0] direction,
   output logic       moved,
   output logic       game_over,
   output logic [1:0] state
);

   localparam int unsigned    CNT_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

   localparam logic [1:0] DIR_RIGHT = 2'b00;
   localparam logic [1:0] DIR_LEFT  = 2'b01;
   localparam logic [1:0] DIR_DOWN  = 2'b10;
   localparam logic [1:0] DIR_UP    = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DEAD = 2'b10
   } state_t;

   // -------------------------------------------------------------------------
   // Helper functions
   // -------------------------------------------------------------------------

   // Opposite directions share the axis bit (bit1) and differ in bit0.
   function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
      return (a[1] == b[1]) && (a[0] != b[0]);
   endfunction

   // True when stepping from h in direction d would leave the grid.
   function automatic logic leaves_grid(input logic [5:0] h, input logic [1:0] d);
      logic [2:0] row;
      logic [2:0] col;
      logic       off;
      row = h[5:3];
      col = h[2:0];
      off = 1'b0;
      case (d)
         DIR_RIGHT: off = (col == 3'd7);
         DIR_LEFT:  off = (col == 3'd0);
         DIR_DOWN:  off = (row == 3'd7);
         DIR_UP:    off = (row == 3'd0);
         default:   off = 1'b0;
      endcase
      return off;
   endfunction

   // Next head position; row and col are independent 3-bit fields so a
   // col step can never carry into the row.
   function automatic logic [5:0] step_head(input logic [5:0] h, input logic [1:0] d);
      logic [2:0] row;
      logic [2:0] col;
      row = h[5:3];
      col = h[2:0];
      case (d)
         DIR_RIGHT: col = col + 3'd1;
         DIR_LEFT:  col = col - 3'd1;
         DIR_DOWN:  row = row + 3'd1;
         DIR_UP:    row = row - 3'd1;
         default:   ;
      endcase
      return {row, col};
   endfunction

   // -------------------------------------------------------------------------
   // State registers and their next values
   // -------------------------------------------------------------------------
   state_t           state_q,    state_d;
   logic [5:0]       head_q,     head_d;
   logic [1:0]       dir_q,      dir_d;
   logic [1:0]       last_dir_q, last_dir_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic             moved_q,    moved_d;

   // -------------------------------------------------------------------------
   // Button priority encoder: UP > DOWN > LEFT > RIGHT
   // -------------------------------------------------------------------------
   logic       req_vld;
   logic [1:0] req_dir;

   always_comb begin
      req_vld = 1'b1;
      req_dir = DIR_RIGHT;
      if (btn_up) begin
         req_dir = DIR_UP;
      end else if (btn_down) begin
         req_dir = DIR_DOWN;
      end else if (btn_left) begin
         req_dir = DIR_LEFT;
      end else if (btn_right) begin
         req_dir = DIR_RIGHT;
      end else begin
         req_vld = 1'b0;
      end
   end

   logic tick;
   assign tick = (cnt_q == CNT_LAST);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      head_d     = head_q;
      dir_d      = dir_q;
      last_dir_d = last_dir_q;
      cnt_d      = cnt_q;
      moved_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end

         S_RUN: begin
            if (tick) begin
               cnt_d = '0;
               // Buttons are ignored here. colide is only trusted on this
               // cycle; the edge guard catches an off-grid step even if the
               // checker missed it, so the head never wraps.
               if (colide || leaves_grid(head_q, dir_q)) begin
                  state_d = S_DEAD;
               end else begin
                  head_d     = step_head(head_q, dir_q);
                  last_dir_d = dir_q;
                  moved_d    = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
               // Reversal is judged against the last direction actually
               // moved, not the pending one, so a 90deg turn can be undone
               // before the tick.
               if (req_vld && !is_opposite(req_dir, last_dir_q)) begin
                  dir_d = req_dir;
               end
            end
         end

         S_DEAD: begin
            if (start) begin
               state_d    = S_IDLE;
               head_d     = START_HEAD;
               dir_d      = START_DIR;
               last_dir_d = START_DIR;
               cnt_d      = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         head_q     <= START_HEAD;
         dir_q      <= START_DIR;
         last_dir_q <= START_DIR;
         cnt_q      <= '0;
         moved_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         dir_q      <= dir_d;
         last_dir_q <= last_dir_d;
         cnt_q      <= cnt_d;
         moved_q    <= moved_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign head      = head_q;
   assign direction = dir_q;
   assign moved     = moved_q;
   assign game_over = (state_q == S_DEAD);
   assign state     = state_q;

endmodule

// File: tb/tb_snake_head_mover.sv
// ============================================================================
// tb_snake_head_mover
// ----------------------------------------------------------------------------
// Directed scenarios followed by randomized stimulus, every cycle compared
// against a behavioural game model that tracks row/col as plain integers.
// ============================================================================
module tb_snake_head_mover;

   localparam int TICK = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic       btn_left = 1'b0;
   logic       btn_right = 1'b0;
   logic       colide = 1'b0;
   logic [5:0] head;
   logic [1:0] direction;
   logic       moved;
   logic       game_over;
   logic [1:0] state;

   int n_chk = 0;
   int n_err = 0;

   // Behavioural model: 0=IDLE 1=RUN 2=DEAD; dir 0=R 1=L 2=D 3=U
   int m_state = 0;
   int m_row   = 3;
   int m_col   = 3;
   int m_dir   = 0;
   int m_last  = 0;
   int m_cnt   = 0;
   int m_moved = 0;

   always #5 clock = ~clock;

   snake_head_mover #(
      .TICK_CYCLES(TICK),
      .START_HEAD (6'b011011),
      .START_DIR  (2'b00)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .btn_left (btn_left),
      .btn_right(btn_right),
      .colide   (colide),
      .head     (head),
      .direction(direction),
      .moved    (moved),
      .game_over(game_over),
      .state    (state)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit rst, input bit s, input bit u, input bit d,
                             input bit l, input bit r, input bit c);
      int dr;
      int dc;
      int nr;
      int nc;
      int req;
      if (rst) begin
         m_state = 0; m_row = 3; m_col = 3; m_dir = 0; m_last = 0;
         m_cnt = 0; m_moved = 0;
         return;
      end
      m_moved = 0;
      case (m_state)
         0: if (s) begin m_state = 1; m_cnt = 0; end
         1: begin
            if (m_cnt == TICK - 1) begin
               m_cnt = 0;
               dr = 0; dc = 0;
               case (m_dir)
                  0: dc = 1;
                  1: dc = -1;
                  2: dr = 1;
                  default: dr = -1;
               endcase
               nr = m_row + dr;
               nc = m_col + dc;
               if (c || nr < 0 || nr > 7 || nc < 0 || nc > 7) begin
                  m_state = 2;
               end else begin
                  m_row = nr; m_col = nc; m_last = m_dir; m_moved = 1;
               end
            end else begin
               m_cnt++;
               req = -1;
               if (u) req = 3;
               else if (d) req = 2;
               else if (l) req = 1;
               else if (r) req = 0;
               // Opposite pairs: R<->L, D<->U
               if (req >= 0 && !((req / 2 == m_last / 2) && (req != m_last)))
                  m_dir = req;
            end
         end
         default: if (s) begin
            m_state = 0; m_row = 3; m_col = 3; m_dir = 0; m_last = 0; m_cnt = 0;
         end
      endcase
   endtask

   task automatic cyc(input bit rst, input bit s, input bit u, input bit d,
                      input bit l, input bit r, input bit c);
      reset = rst; start = s; btn_up = u; btn_down = d;
      btn_left = l; btn_right = r; colide = c;
      @(posedge clock);
      model_step(rst, s, u, d, l, r, c);
      @(negedge clock);
      chk("head",      32'(head),      32'(m_row * 8 + m_col));
      chk("direction", 32'(direction), 32'(m_dir));
      chk("moved",     32'(moved),     32'(m_moved));
      chk("game_over", 32'(game_over), 32'(m_state == 2));
      chk("state",     32'(state),     32'(m_state));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // 1: reset, straight run, collision on the tick
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("rst_head",  32'(head), 32'h1b);
      chk("rst_state", 32'(state), 32'd0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      idle(16);
      chk("t1_head", 32'(head), 32'(6'b011111));
      idle(3);
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("t1_state", 32'(state), 32'd2);
      chk("t1_go",    32'(game_over), 32'd1);
      chk("t1_hold",  32'(head), 32'(6'b011111));

      // 5: re-init, run to the right edge, edge guard with colide=0
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("t5_idle_head", 32'(head), 32'(6'b011011));
      chk("t5_idle_dir",  32'(direction), 32'd0);
      chk("t5_idle_st",   32'(state), 32'd0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      idle(16);
      idle(4);
      chk("t5_edge_state", 32'(state), 32'd2);
      chk("t5_edge_head",  32'(head), 32'(6'b011111));
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("t5_reinit_head", 32'(head), 32'(6'b011011));
      chk("t5_reinit_dir",  32'(direction), 32'd0);

      // 2: reversal rejected, then turn up
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("t2_left_rej", 32'(direction), 32'd0);
      cyc(0, 0, 1, 0, 0, 0, 0);
      chk("t2_up", 32'(direction), 32'd3);
      idle(2);
      chk("t2_head", 32'(head), 32'(6'b010011));

      // 3: back to RIGHT, then up-then-down before the tick
      cyc(0, 0, 0, 0, 0, 1, 0);
      idle(3);
      chk("t3_head_r", 32'(head), 32'(6'b010100));
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("t3_dir", 32'(direction), 32'd2);
      idle(2);
      chk("t3_head", 32'(head), 32'(6'b011100));

      // 4: priority, and a press on the tick cycle is ignored
      cyc(0, 0, 0, 0, 0, 1, 0);
      idle(3);
      cyc(0, 0, 1, 0, 1, 0, 0);
      chk("t4_prio", 32'(direction), 32'd3);
      idle(2);
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("t4_tick_dir",  32'(direction), 32'd3);
      chk("t4_tick_head", 32'(head), 32'(6'b010101));

      // 6: reset on a tick cycle
      idle(3);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("t6_state", 32'(state), 32'd0);
      chk("t6_head",  32'(head), 32'(6'b011011));
      chk("t6_dir",   32'(direction), 32'd0);
      chk("t6_moved", 32'(moved), 32'd0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      idle(4);
      chk("t6_cnt_head",  32'(head), 32'(6'b011100));
      chk("t6_cnt_moved", 32'(moved), 32'd1);

      // Randomized play against the model
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 299) == 0,
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 29) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
